// File: rtl/link_pkt_tx_pkg.sv
// Shared definitions for the link packet transmitter and its matching receiver:
// FSM state encoding and header field placement.
package link_pkt_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    // Length field is LSB-aligned; destination is MSB-aligned in the header word.
    localparam int LEN_LSB = 0;

    function automatic int dst_lsb(input int word_w, input int dst_w);
        return word_w - dst_w;
    endfunction

endpackage

// File: rtl/link_out_slot.sv
// Registered valid/stall output slot: holds one word, loads only when the
// downstream can take it (empty slot or word consumed this cycle).
module link_out_slot #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_stall,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_ready
);

    logic [W-1:0] r_data;
    logic         r_valid;
    logic         w_ready;

    assign w_ready = ~r_valid | ~i_stall;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_ready) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ready = w_ready;

endmodule

// File: rtl/link_pkt_tx.sv
// Packet transmitter: frames a request and its payload words into
// header + payload, flagging the final word with o_last.
import link_pkt_tx_pkg::*;

module link_pkt_tx #(
    parameter int N     = 32,
    parameter int DST_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    input  logic [DST_W-1:0] i_req_dst,
    input  logic [LEN_W-1:0] i_req_len,
    output logic             o_req_stall,
    input  logic [N-1:0]     i_pl_data,
    input  logic             i_pl_valid,
    output logic             o_pl_stall,
    output logic [N-1:0]     o_data,
    output logic             o_last,
    output logic             o_valid,
    input  logic             i_stall,
    output logic             o_busy
);

    localparam int DST_LSB = dst_lsb(N, DST_W);

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_next_cnt;
    logic             w_load;
    logic [N:0]       w_slot_data;
    logic [N:0]       w_slot_q;
    logic             w_ready;
    logic [N-1:0]     w_hdr;

    link_out_slot #(
        .W (N + 1)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_slot_data),
        .i_stall (i_stall),
        .o_data  (w_slot_q),
        .o_valid (o_valid),
        .o_ready (w_ready)
    );

    always_comb begin
        w_hdr = '0;
        w_hdr[DST_LSB +: DST_W] = i_req_dst;
        w_hdr[LEN_LSB +: LEN_W] = i_req_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_load       = 1'b0;
        w_slot_data  = '0;
        o_req_stall  = 1'b1;
        o_pl_stall   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_req_stall = ~w_ready;
                if (i_req_valid && w_ready) begin
                    w_load       = 1'b1;
                    w_slot_data  = {1'b0, w_hdr};
                    w_next_cnt   = i_req_len;
                    w_next_state = ST_BODY;
                end
            end
            ST_BODY: begin
                o_pl_stall = ~w_ready;
                if (i_pl_valid && w_ready) begin
                    w_load = 1'b1;
                    // Exit on the final word before the counter could pass zero.
                    if (r_cnt == '0) begin
                        w_slot_data  = {1'b1, i_pl_data};
                        w_next_state = ST_IDLE;
                    end else begin
                        w_slot_data = {1'b0, i_pl_data};
                        w_next_cnt  = r_cnt - LEN_W'(1);
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_data = w_slot_q[N-1:0];
    assign o_last = w_slot_q[N];
    assign o_busy = (r_state == ST_BODY) | o_valid;

endmodule

// File: tb/tb_link_pkt_tx.sv
// Self-checking bench for link_pkt_tx: directed scenarios plus randomized
// handshakes, checked against a packet-level expected word stream.
module tb_link_pkt_tx;

    localparam int N     = 32;
    localparam int DST_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_req_valid = 1'b0;
    logic [DST_W-1:0] i_req_dst = '0;
    logic [LEN_W-1:0] i_req_len = '0;
    logic             o_req_stall;
    logic [N-1:0]     i_pl_data = '0;
    logic             i_pl_valid = 1'b0;
    logic             o_pl_stall;
    logic [N-1:0]     o_data;
    logic             o_last;
    logic             o_valid;
    logic             i_stall = 1'b0;
    logic             o_busy;

    always #5 clk = ~clk;

    link_pkt_tx #(.N(N), .DST_W(DST_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_dst   (i_req_dst),
        .i_req_len   (i_req_len),
        .o_req_stall (o_req_stall),
        .i_pl_data   (i_pl_data),
        .i_pl_valid  (i_pl_valid),
        .o_pl_stall  (o_pl_stall),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_valid     (o_valid),
        .i_stall     (i_stall),
        .o_busy      (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected stream built from packet descriptions; received stream from the monitor.
    logic [N:0]       exp_q[$];
    logic [N:0]       got_q[$];
    int               got_cyc[$];
    logic [N-1:0]     pl_q[$];
    logic [DST_W-1:0] rq_dst[$];
    logic [LEN_W-1:0] rq_len[$];

    bit           mon_en = 1'b0;
    bit           run_done = 1'b0;
    int           deadline = 0;
    int           stall_pct = 0;
    int           gap_pct = 0;
    int           req_delay = 0;
    logic [N-1:0] stall_target = '1;
    int           stall_left = 0;
    int           hold_cnt = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n && o_valid && !i_stall) begin
            got_q.push_back({o_last, o_data});
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input logic [DST_W-1:0] dst, input logic [LEN_W-1:0] len,
                           input logic [N-1:0] base, input bit rnd);
        logic [N-1:0] hdr;
        logic [N-1:0] w;
        hdr = (N'(dst) << (N - DST_W)) | N'(len);
        rq_dst.push_back(dst);
        rq_len.push_back(len);
        exp_q.push_back({1'b0, hdr});
        for (int i = 0; i <= int'(len); i++) begin
            w = rnd ? N'($urandom) : base + N'(i);
            pl_q.push_back(w);
            exp_q.push_back({(i == int'(len)), w});
        end
    endtask

    task automatic req_drv();
        bit acc;
        for (int d = 0; d < req_delay; d++) begin
            @(negedge clk);
            check("idle_pl_stall", o_pl_stall, 1);
            check("idle_no_out", o_valid, 0);
            @(posedge clk); #1;
        end
        while (rq_dst.size() > 0 && cyc < deadline) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_req_valid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            i_req_valid = 1'b1;
            i_req_dst   = rq_dst[0];
            i_req_len   = rq_len[0];
            @(negedge clk);
            acc = !o_req_stall;
            @(posedge clk); #1;
            if (acc) begin
                void'(rq_dst.pop_front());
                void'(rq_len.pop_front());
            end
        end
        i_req_valid = 1'b0;
    endtask

    task automatic pl_drv();
        bit acc;
        while (pl_q.size() > 0 && cyc < deadline) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_pl_valid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            i_pl_valid = 1'b1;
            i_pl_data  = pl_q[0];
            @(negedge clk);
            acc = !o_pl_stall;
            @(posedge clk); #1;
            if (acc) void'(pl_q.pop_front());
        end
        i_pl_valid = 1'b0;
    endtask

    task automatic stall_drv();
        bit         prev_stalled;
        logic [N:0] prev_word;
        prev_stalled = 1'b0;
        prev_word    = '0;
        while (!run_done && cyc < deadline) begin
            if (stall_left > 0 && o_valid && o_data === stall_target) begin
                i_stall = 1'b1;
                stall_left--;
            end else begin
                i_stall = (stall_pct > 0 && $urandom_range(99) < stall_pct);
            end
            @(negedge clk);
            if (prev_stalled) begin
                check("stall_hold_word", {o_last, o_data}, prev_word);
                check("stall_hold_valid", o_valid, 1);
            end
            if (o_valid && o_data === stall_target) hold_cnt++;
            if (i_stall && o_valid) begin
                check("stall_pl_stall", o_pl_stall, 1);
                check("stall_req_stall", o_req_stall, 1);
            end
            prev_stalled = i_stall && o_valid;
            prev_word    = {o_last, o_data};
            @(posedge clk); #1;
        end
        i_stall = 1'b0;
    endtask

    task automatic waiter();
        while (got_q.size() < exp_q.size() && cyc < deadline) @(posedge clk);
        run_done = 1'b1;
    endtask

    task automatic run_stream(input int s_pct, input int g_pct, input int r_delay, input int max_cyc);
        stall_pct = s_pct;
        gap_pct   = g_pct;
        req_delay = r_delay;
        got_q.delete();
        got_cyc.delete();
        run_done = 1'b0;
        deadline = cyc + max_cyc;
        mon_en   = 1'b1;
        fork
            req_drv();
            pl_drv();
            stall_drv();
            waiter();
        join
        mon_en = 1'b0;
        check("word_count", N'(got_q.size()), N'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("word[%0d]", i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        // Reset values, during and after reset
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        check("rst_req_stall", o_req_stall, 0);
        check("rst_pl_stall", o_pl_stall, 1);
        check("rst_busy", o_busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_stall", o_req_stall, 0);
        check("post_rst_pl_stall", o_pl_stall, 1);
        check("post_rst_busy", o_busy, 0);

        // Reset asserted mid-BODY abandons the packet
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_dst = 8'h33; i_req_len = 4'd5;
        i_pl_valid  = 1'b1; i_pl_data = 32'hDEAD_0001;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_body_busy", o_busy, 1);
        check("mid_body_req_stall", o_req_stall, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_last", o_last, 0);
        check("midrst_req_stall", o_req_stall, 0);
        check("midrst_pl_stall", o_pl_stall, 1);
        check("midrst_busy", o_busy, 0);
        @(negedge clk);
        i_pl_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single packet dst 5A len 2, dense, busy drops after the last word
        add_pkt(8'h5A, 4'd2, 32'hA1, 1'b0);
        run_stream(0, 0, 0, 100);
        if (got_q.size() > 0) begin
            check("hdr_5a", got_q[0], {1'b0, 32'h5A00_0002});
            check("dense_single", N'(got_cyc[got_cyc.size()-1] - got_cyc[0]), N'(got_q.size() - 1));
        end
        exp_q.delete();
        @(negedge clk);
        check("busy_after", o_busy, 0);
        @(posedge clk); #1;

        // Back-to-back: len 0 then len 1, 5 words in 5 cycles
        add_pkt(8'h01, 4'd0, 32'h100, 1'b0);
        add_pkt(8'h02, 4'd1, 32'h200, 1'b0);
        run_stream(0, 0, 0, 100);
        if (got_q.size() > 0) begin
            check("dense_b2b", N'(got_cyc[got_cyc.size()-1] - got_cyc[0]), 4);
        end
        exp_q.delete();
        @(posedge clk); #1;

        // Stall held 3 cycles on a payload word: visible for exactly 4 cycles
        add_pkt(8'hC0, 4'd3, 32'hC0, 1'b0);
        stall_target = 32'hC2;
        stall_left   = 3;
        hold_cnt     = 0;
        run_stream(0, 0, 0, 100);
        check("stall_hold_cycles", N'(hold_cnt), 4);
        stall_target = '1;
        stall_left   = 0;
        exp_q.delete();
        @(posedge clk); #1;

        // Payload waiting in IDLE, then a full-length packet with gaps
        add_pkt(8'h77, 4'd15, 32'h0, 1'b1);
        run_stream(0, 40, 5, 1000);
        exp_q.delete();
        @(posedge clk); #1;

        // Randomized requests, payload gaps and downstream stalls
        for (int p = 0; p < 20; p++) begin
            add_pkt(DST_W'($urandom), LEN_W'($urandom), 32'h0, 1'b1);
        end
        run_stream(30, 25, 0, 5000);
        exp_q.delete();
        @(posedge clk); #1;

        for (int p = 0; p < 10; p++) begin
            add_pkt(DST_W'($urandom), LEN_W'($urandom), 32'h0, 1'b1);
        end
        run_stream(60, 0, 0, 5000);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
